// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// This file holds the FSM state encoding and the default data and address widths.
package rf_write_arbiter_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rf_write_arbiter_rr.sv
// Two-way round-robin arbiter used by rf_write_arbiter.
// A sole requester always wins. When both request, the one that was not
// granted last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Pick a one-hot winner; on a tie, favour the side opposite to 'last'
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two write requesters onto a single register-file write port.
// The grant is combinational. The write appears on the register-file port
// one cycle after it is accepted.
// Optional feature: define RF_WRITE_ARB_STATS_EN to add the saturating
// per-requester grant counters Grant0_cnt and Grant1_cnt.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Hold,
    input  logic              Req0_valid,
    input  logic [ADDR_W-1:0] Req0_addr,
    input  logic [DATA_W-1:0] Req0_data,
    input  logic              Req1_valid,
    input  logic [ADDR_W-1:0] Req1_addr,
    input  logic [DATA_W-1:0] Req1_data,
    output logic              Req0_ready,
    output logic              Req1_ready,
    output logic [ADDR_W-1:0] RegEsc,
    output logic [DATA_W-1:0] Dado,
    output logic              Esc,
    output logic              Owner
`ifdef RF_WRITE_ARB_STATS_EN
    ,
    output logic [15:0]       Grant0_cnt,
    output logic [15:0]       Grant1_cnt
`endif
);

    logic [1:0] rst_sync;
    logic       run;
    logic [1:0] req;
    logic [1:0] grant;
    logic       last_grant;
    arb_state_e state;

    // Synchronise reset release so that grants start only after two clean edges
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];
    assign req = {Req1_valid, Req0_valid} & {2{run & ~Hold}};

    rr_arbiter2 u_rr (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    assign Req0_ready = grant[0];
    assign Req1_ready = grant[1];

    // Write FSM: capture the accepted request and move the round-robin pointer
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            RegEsc     <= '0;
            Dado       <= '0;
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            state      <= WR0;
            RegEsc     <= Req0_addr;
            Dado       <= Req0_data;
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            state      <= WR1;
            RegEsc     <= Req1_addr;
            Dado       <= Req1_data;
            last_grant <= 1'b1;
        end else begin
            state      <= IDLE;
        end
    end

    assign Esc   = (state != IDLE);
    assign Owner = (state == WR1);

`ifdef RF_WRITE_ARB_STATS_EN
    // Count accepted transfers per requester, sticking at all-ones
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Grant0_cnt <= 16'h0000;
            Grant1_cnt <= 16'h0000;
        end else begin
            if (grant[0] && Grant0_cnt != 16'hFFFF) begin
                Grant0_cnt <= Grant0_cnt + 16'h0001;
            end
            if (grant[1] && Grant1_cnt != 16'hFFFF) begin
                Grant1_cnt <= Grant1_cnt + 16'h0001;
            end
        end
    end
`else
    // The statistics counters are left out of this build.
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a
// randomized run checked against a behavioural reference model.
module tb_rf_write_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Hold;
    logic        Req0_valid, Req1_valid;
    logic [1:0]  Req0_addr, Req1_addr;
    logic [31:0] Req0_data, Req1_data;
    logic        Req0_ready, Req1_ready;
    logic [1:0]  RegEsc;
    logic [31:0] Dado;
    logic        Esc, Owner;
`ifdef RF_WRITE_ARB_STATS_EN
    logic [15:0] Grant0_cnt, Grant1_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: abstract state derived from the arbitration rules
    int          m_last;
    logic        m_esc, m_owner;
    logic [1:0]  m_addr;
    logic [31:0] m_data;
    int          m_edges;
    logic        exp_r0, exp_r1;
    logic [31:0] shadow [4];

    rf_write_arbiter dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Hold       (Hold),
        .Req0_valid (Req0_valid),
        .Req0_addr  (Req0_addr),
        .Req0_data  (Req0_data),
        .Req1_valid (Req1_valid),
        .Req1_addr  (Req1_addr),
        .Req1_data  (Req1_data),
        .Req0_ready (Req0_ready),
        .Req1_ready (Req1_ready),
        .RegEsc     (RegEsc),
        .Dado       (Dado),
        .Esc        (Esc),
        .Owner      (Owner)
`ifdef RF_WRITE_ARB_STATS_EN
        ,
        .Grant0_cnt (Grant0_cnt),
        .Grant1_cnt (Grant1_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Register file fed by the arbiter's write port
    always @(posedge Clk) begin
        if (Rst_n && Esc) shadow[RegEsc] <= Dado;
    end

    task automatic model_reset();
        m_last  = 1;
        m_esc   = 1'b0;
        m_owner = 1'b0;
        m_addr  = 2'd0;
        m_data  = 32'd0;
        m_edges = 0;
    endtask

    task automatic predict();
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (Rst_n && !Hold && m_edges >= 2) begin
            if (Req0_valid && Req1_valid) begin
                if (m_last == 1) exp_r0 = 1'b1;
                else             exp_r1 = 1'b1;
            end else if (Req0_valid) begin
                exp_r0 = 1'b1;
            end else if (Req1_valid) begin
                exp_r1 = 1'b1;
            end
        end
    endtask

    task automatic advance();
        predict();
        @(posedge Clk);
        if (exp_r0 || exp_r1) begin
            m_esc   = 1'b1;
            m_owner = exp_r1;
            m_addr  = exp_r1 ? Req1_addr : Req0_addr;
            m_data  = exp_r1 ? Req1_data : Req0_data;
            m_last  = exp_r1 ? 1 : 0;
        end else begin
            m_esc = 1'b0;
        end
        m_edges++;
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Hold = 1'b0;
        Req0_valid = 1'b1; Req0_addr = 2'd1; Req0_data = 32'hAAAA_0001;
        Req1_valid = 1'b1; Req1_addr = 2'd1; Req1_data = 32'hBBBB_0002;
        model_reset();
        #2;
        checks++; if (Esc !== 1'b0) begin errors++; $display("[TB] FAIL reset_esc got %b exp 0", Esc); end
        checks++; if (Owner !== 1'b0) begin errors++; $display("[TB] FAIL reset_owner got %b exp 0", Owner); end
        checks++; if (RegEsc !== 2'd0) begin errors++; $display("[TB] FAIL reset_regesc got %0d exp 0", RegEsc); end
        checks++; if (Dado !== 32'd0) begin errors++; $display("[TB] FAIL reset_dado got %h exp 0", Dado); end
        checks++; if ({Req1_ready, Req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got %b exp 00", {Req1_ready, Req0_ready}); end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            checks++; if ({Req1_ready, Req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL sync_ready%0d got %b exp 00", i, {Req1_ready, Req0_ready}); end
            advance();
        end
    endtask

    task automatic test_tie_after_reset();
        @(negedge Clk);
        checks++; if ({Req1_ready, Req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL tie_first got %b exp 01", {Req1_ready, Req0_ready}); end
        advance();
        Req0_valid = 1'b0;
        @(negedge Clk);
        checks++; if ({Req1_ready, Req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL tie_second got %b exp 10", {Req1_ready, Req0_ready}); end
        checks++; if ({Esc, Owner, RegEsc, Dado} !== {1'b1, 1'b0, 2'd1, 32'hAAAA_0001}) begin errors++; $display("[TB] FAIL tie_wr0 got esc %b own %b a %0d d %h", Esc, Owner, RegEsc, Dado); end
        advance();
        Req1_valid = 1'b0;
        @(negedge Clk);
        checks++; if ({Esc, Owner, RegEsc, Dado} !== {1'b1, 1'b1, 2'd1, 32'hBBBB_0002}) begin errors++; $display("[TB] FAIL tie_wr1 got esc %b own %b a %0d d %h", Esc, Owner, RegEsc, Dado); end
        advance();
    endtask

    task automatic test_single();
        Req0_valid = 1'b1; Req0_addr = 2'd2; Req0_data = 32'h048fc24a;
        @(negedge Clk);
        checks++; if ({Req1_ready, Req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got %b exp 01", {Req1_ready, Req0_ready}); end
        advance();
        Req0_valid = 1'b0;
        @(negedge Clk);
        checks++; if ({Esc, Owner, RegEsc, Dado} !== {1'b1, 1'b0, 2'd2, 32'h048fc24a}) begin errors++; $display("[TB] FAIL single_write got esc %b own %b a %0d d %h", Esc, Owner, RegEsc, Dado); end
        advance();
        @(negedge Clk);
        checks++; if ({Esc, RegEsc, Dado} !== {1'b0, 2'd2, 32'h048fc24a}) begin errors++; $display("[TB] FAIL single_hold got esc %b a %0d d %h", Esc, RegEsc, Dado); end
        advance();
    endtask

    task automatic test_alternate();
        int n0 = 0;
        int n1 = 0;
        logic [1:0] prev = 2'b00;
`ifdef RF_WRITE_ARB_STATS_EN
        logic [15:0] c0 = Grant0_cnt;
        logic [15:0] c1 = Grant1_cnt;
`endif
        Req0_valid = 1'b1; Req0_addr = 2'($urandom); Req0_data = $urandom;
        Req1_valid = 1'b1; Req1_addr = 2'($urandom); Req1_data = $urandom;
        for (int i = 0; i < 8; i++) begin
            predict();
            @(negedge Clk);
            checks++; if ({Req1_ready, Req0_ready} !== {exp_r1, exp_r0}) begin errors++; $display("[TB] FAIL alt_ready%0d got %b exp %b", i, {Req1_ready, Req0_ready}, {exp_r1, exp_r0}); end
            if (i > 0) begin
                checks++; if ({Req1_ready, Req0_ready} !== ~prev) begin errors++; $display("[TB] FAIL alt_order%0d got %b exp %b", i, {Req1_ready, Req0_ready}, ~prev); end
            end
            prev = {Req1_ready, Req0_ready};
            if (Req0_ready) n0++;
            if (Req1_ready) n1++;
            advance();
            if (prev[0]) begin Req0_addr = 2'($urandom); Req0_data = $urandom; end
            if (prev[1]) begin Req1_addr = 2'($urandom); Req1_data = $urandom; end
        end
        checks++; if (n0 !== 4 || n1 !== 4) begin errors++; $display("[TB] FAIL alt_counts got %0d/%0d exp 4/4", n0, n1); end
`ifdef RF_WRITE_ARB_STATS_EN
        checks++; if ((Grant0_cnt - c0) !== 16'd4 || (Grant1_cnt - c1) !== 16'd4) begin errors++; $display("[TB] FAIL stats_counts got %0d/%0d exp 4/4", Grant0_cnt - c0, Grant1_cnt - c1); end
`endif
        Req0_valid = 1'b0; Req1_valid = 1'b0;
        advance();
    endtask

    task automatic test_same_addr();
        Req1_valid = 1'b1; Req1_addr = 2'd0; Req1_data = $urandom;
        advance();
        Req1_valid = 1'b0;
        advance();
        Req0_valid = 1'b1; Req0_addr = 2'd3; Req0_data = 32'h00000004;
        Req1_valid = 1'b1; Req1_addr = 2'd3; Req1_data = 32'h00000002;
        @(negedge Clk);
        checks++; if ({Req1_ready, Req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL same_first got %b exp 01", {Req1_ready, Req0_ready}); end
        advance();
        Req0_valid = 1'b0;
        @(negedge Clk);
        checks++; if ({Req1_ready, Req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL same_second got %b exp 10", {Req1_ready, Req0_ready}); end
        advance();
        Req1_valid = 1'b0;
        checks++; if (shadow[3] !== 32'h00000004) begin errors++; $display("[TB] FAIL same_mid got %h exp 00000004", shadow[3]); end
        advance();
        advance();
        checks++; if (shadow[3] !== 32'h00000002) begin errors++; $display("[TB] FAIL same_final got %h exp 00000002", shadow[3]); end
    endtask

    task automatic test_hold();
        Hold = 1'b1;
        Req0_valid = 1'b1; Req0_addr = 2'($urandom); Req0_data = $urandom;
        Req1_valid = 1'b1; Req1_addr = 2'($urandom); Req1_data = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++; if ({Req1_ready, Req0_ready, Esc} !== 3'b000) begin errors++; $display("[TB] FAIL hold%0d got rdy %b esc %b exp 00/0", i, {Req1_ready, Req0_ready}, Esc); end
            advance();
        end
        Hold = 1'b0;
        predict();
        @(negedge Clk);
        checks++; if ({Req1_ready, Req0_ready} !== {exp_r1, exp_r0} || (exp_r0 == exp_r1)) begin errors++; $display("[TB] FAIL hold_release got %b exp %b", {Req1_ready, Req0_ready}, {exp_r1, exp_r0}); end
        advance();
        Req0_valid = 1'b0; Req1_valid = 1'b0;
        advance();
    endtask

    task automatic test_reset_midwrite();
        Req1_valid = 1'b1; Req1_addr = 2'd2; Req1_data = $urandom;
        advance();
        Req1_valid = 1'b0;
        @(negedge Clk);
        checks++; if (Esc !== 1'b1) begin errors++; $display("[TB] FAIL mid_esc_before got %b exp 1", Esc); end
        #1;
        Rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({Esc, Owner, Dado} !== {1'b0, 1'b0, 32'd0}) begin errors++; $display("[TB] FAIL mid_async got esc %b own %b d %h exp 0/0/0", Esc, Owner, Dado); end
        Req0_valid = 1'b1; Req0_addr = 2'($urandom); Req0_data = $urandom;
        Req1_valid = 1'b1; Req1_addr = 2'($urandom); Req1_data = $urandom;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        advance();
        advance();
        @(negedge Clk);
        checks++; if ({Req1_ready, Req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL mid_tie got %b exp 01", {Req1_ready, Req0_ready}); end
        advance();
        Req0_valid = 1'b0; Req1_valid = 1'b0;
        advance();
    endtask

    task automatic test_random();
        logic g0 = 1'b1;
        logic g1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!Req0_valid || g0) begin
                Req0_valid = ($urandom_range(0, 9) < 6);
                Req0_addr = 2'($urandom); Req0_data = $urandom;
            end
            if (!Req1_valid || g1) begin
                Req1_valid = ($urandom_range(0, 9) < 6);
                Req1_addr = 2'($urandom); Req1_data = $urandom;
            end
            Hold = ($urandom_range(0, 9) < 2);
            predict();
            @(negedge Clk);
            checks++; if ({Req1_ready, Req0_ready} !== {exp_r1, exp_r0}) begin errors++; $display("[TB] FAIL rnd_ready@%0d got %b exp %b", i, {Req1_ready, Req0_ready}, {exp_r1, exp_r0}); end
            checks++; if ({Esc, RegEsc, Dado} !== {m_esc, m_addr, m_data}) begin errors++; $display("[TB] FAIL rnd_port@%0d got %b/%0d/%h exp %b/%0d/%h", i, Esc, RegEsc, Dado, m_esc, m_addr, m_data); end
            if (m_esc) begin
                checks++; if (Owner !== m_owner) begin errors++; $display("[TB] FAIL rnd_owner@%0d got %b exp %b", i, Owner, m_owner); end
            end
            g0 = exp_r0;
            g1 = exp_r1;
            advance();
        end
        Hold = 1'b0; Req0_valid = 1'b0; Req1_valid = 1'b0;
        advance();
    endtask

    initial begin
        test_reset();
        test_tie_after_reset();
        test_single();
        test_alternate();
        test_same_addr();
        test_hold();
        test_reset_midwrite();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 2, register address width (4 registers).
REQ-003 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Hold  input  1  stall; blocks all grants while high.
REQ-006 SHALL have ports Req0_valid / Req1_valid  input  1  write request from requester 0 / 1.
REQ-007 SHALL have ports Req0_addr / Req1_addr  input  ADDR_W  destination register.
REQ-008 SHALL have ports Req0_data / Req1_data  input  DATA_W  write data.
REQ-009 SHALL have ports Req0_ready / Req1_ready  output  1  grant; transfer occurs on valid and ready.
REQ-010 SHALL have port RegEsc  output  ADDR_W  register-file write address.
REQ-011 SHALL have port Dado  output  DATA_W  register-file write data.
REQ-012 SHALL have port Esc  output  1  register-file write enable.
REQ-013 SHALL have port Owner  output  1  requester that owns the current write; meaningful only when Esc=1.

Function
REQ-014 Ready SHALL be combinational: at most one ReqN_ready high per cycle; both SHALL be low when Hold=1.
REQ-015 Only requester valid -> that requester granted.
REQ-016 Both valid -> requester other than last-granted SHALL be granted (round-robin); last-granted pointer SHALL update only on an accepted transfer.
REQ-017 Accepted transfer SHALL appear on RegEsc/Dado/Esc=1/Owner at the next rising edge: latency 1 cycle; Esc high exactly one cycle per transfer.
REQ-018 No transfer in a cycle -> Esc=0 next cycle; RegEsc/Dado SHALL hold their last values.
REQ-019 FSM states: IDLE (Esc=0), WR0 (writing for requester 0), WR1 (writing for requester 1); next state = WR0/WR1 per grant, else IDLE; every state SHALL reach every state in one cycle.
REQ-020 Sustained throughput SHALL be one write per cycle; back-to-back grants to the same requester SHALL be allowed when the other is idle.
REQ-021 Both valid to same address -> writes SHALL be serialised in grant order on consecutive cycles, so the later grant's data is the final register value; no merging.
REQ-022 Requester SHALL keep valid/addr/data stable until ready; arbiter SHALL not depend on withdrawn requests.
REQ-023 Hold asserted while requests are pending -> no grant, Esc=0 next cycle, pointer unchanged.

Reset
REQ-024 Rst_n low SHALL immediately force Esc=0, Owner=0, RegEsc=0, Dado=0, state IDLE, last-granted=1 (requester 0 wins first tie).
REQ-025 Reset asserted mid-write SHALL drop the pending Esc at once; the in-flight write is lost.
REQ-026 Release of Rst_n SHALL be synchronised internally so the first grant occurs no earlier than the second rising edge after release.

Configuration
REQ-027 Macro RF_WRITE_ARB_STATS_EN defined -> outputs Grant0_cnt and Grant1_cnt (16 bits each) SHALL count accepted transfers per requester, saturate at 16'hFFFF, and reset to 0.
REQ-028 Macro undefined -> those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (IDLE/WR0/WR1) and default widths (DATA_W=32, ADDR_W=2).
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output one-hot grant).

Verification
REQ-031 Req0 only, addr=2, data=32'h048fc24a -> Req0_ready=1 same cycle; next cycle Esc=1, RegEsc=2, Dado=32'h048fc24a, Owner=0.
REQ-032 Both valid after reset -> requester 0 granted first, requester 1 next cycle; Esc high two consecutive cycles with Owner 0 then 1.
REQ-033 Both continuously valid 8 cycles -> grants alternate 0,1,0,1...; Grant0_cnt=Grant1_cnt=4 when stats enabled.
REQ-034 Both write addr=3, data 32'h00000004 and 32'h00000002 -> register 3 reads 32'h00000002 after two cycles.
REQ-035 Hold=1 for 3 cycles with both valid -> both ready=0, Esc=0 throughout; first grant after Hold drops follows the pointer.
REQ-036 Rst_n pulsed low while Esc=1 -> Esc=0 without a clock edge; after release, requester 0 wins the first tie.
